timx_cfg_seq: RTL and testbench
===============================

Name: timx_cfg_seq

Overview:
- APB master that replays a register-write script into the advanced timer (apoip_timer) after reset or on software request.
- Typical script: ARR, CCR1, CCMR1, CCER, BDTR, EGR.UG, then CR1.CEN.
- Script entries come from an external table (ROM or registers) through a combinational index/lookup interface.
- Sits between system control and the timer's APB slave port; shares nothing else.

Parameters:
- IDX_W, 4, script index width; maximum 2^IDX_W entries.
- TO_W, 8, PREADY timeout counter width.
- TO_MAX, 8'd200, cycles in ACCESS without PREADY before an error is flagged.

Ports:
- apb_clk  in  1  single clock.
- apb_rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle pulse; begins the script at index 0. Ignored while busy.
- abort  in  1  level; terminates the script at the next APB transfer boundary.
- tbl_idx  out  IDX_W  current script index.
- tbl_addr  in  16  register address for tbl_idx (combinational).
- tbl_data  in  32  write data for tbl_idx.
- tbl_last  in  1  tbl_idx is the final entry.
- tbl_nochk  in  1  skip read-back verify for this entry (EGR, self-clearing bits).
- timx_psel  out  1  APB select.
- timx_penable  out  1  APB enable.
- timx_pwrite  out  1  APB direction.
- timx_paddr  out  16  APB address.
- timx_pwdata  out  32  APB write data.
- timx_prdata  in  32  APB read data.
- timx_pready  in  1  APB ready; tie to 1 for the timer.
- timx_pslverr  in  1  APB slave error.
- busy  out  1  script in progress.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  sticky error; cleared by start.
- err_idx  out  IDX_W  index of the first failing entry.

Behaviour:
- Reset values: all outputs 0; state IDLE; tbl_idx 0.
- States:
  - IDLE: on start, tbl_idx←0, err←0, busy←1, go to SETUP.
  - SETUP: psel=1, penable=0, pwrite=1; paddr/pwdata registered from the table. Next cycle goes to ACCESS.
  - ACCESS: psel=1, penable=1. The transfer completes on the first cycle with pready=1.
    - pslverr=1 at completion: err←1, err_idx←tbl_idx, go to IDLE.
    - Otherwise, go to VSETUP (verify enabled and tbl_nochk=0) or NEXT.
  - NEXT: if tbl_last or abort, go to IDLE; otherwise tbl_idx++ and go to SETUP.
  - IDLE entry after success (not abort, no error): done pulses one cycle. busy←0 on any entry to IDLE.
- Timing:
  - Each write takes exactly 3 cycles with pready=1 (SETUP, ACCESS, NEXT).
  - tbl_* are sampled only in SETUP.
  - psel is low in NEXT and IDLE.
- Timeout:
  - A counter clears in SETUP and increments each ACCESS cycle with pready=0.
  - At TO_MAX: err←1, err_idx←tbl_idx, psel/penable←0, go to IDLE.
- Wrap: tbl_idx at 2^IDX_W−1 without tbl_last ends the script as if tbl_last were set; no wrap to 0.
- Simultaneous events:
  - start while busy is ignored.
  - abort and pslverr on the same cycle: error wins.
  - abort never cuts an APB transfer mid-phase.
- Asynchronous reset mid-transfer: psel/penable drop immediately and the script is lost; software must re-issue start.

Optional Feature:
- TIMX_CFG_VERIFY_EN defined:
  - States VSETUP (psel=1, pwrite=0, same paddr) and VACCESS are added.
  - On pready in VACCESS, timx_prdata is compared with the registered pwdata.
  - Mismatch or pslverr: err←1, err_idx←tbl_idx, go to IDLE.
  - Match: go to NEXT. The timeout applies to VACCESS too.
  - Write-plus-verify costs 5 cycles.
- Undefined: VSETUP/VACCESS are not built, tbl_nochk is ignored, and timx_prdata is unused.

Decomposition:
- Package timx_cfg_pkg holds:
  - the state encoding: IDLE, SETUP, ACCESS, VSETUP, VACCESS, NEXT;
  - timer register offsets: CR1 16'h0000, EGR 16'h0014, CCMR1 16'h0018, CCER 16'h0020, ARR 16'h002C, CCR1 16'h0034, BDTR 16'h0044.
- Sub-module timx_cfg_rom: default script table indexed by tbl_idx. Entries:
  - ARR=8
  - CCR1=2
  - CCMR1=0x38
  - CCER=0x5
  - BDTR=0x8000
  - EGR=0x1, nochk
  - CR1=0x1, last

Test Plan:
- Default ROM, pready=1, start at t0 → 7 writes in 21 cycles. paddr sequence 2C,34,18,20,44,14,00; done pulses once; err=0; the timer counts with ARR=8.
- pready held low for 3 cycles on entry 2 → ACCESS is extended 3 cycles; same data written; no error.
- pready stuck at 0 on entry 3 → err=1, err_idx=3 after TO_MAX cycles; psel=0; no done.
- pslverr=1 on entry 4 → err=1, err_idx=4; no further transfers; a new start clears err and reruns from index 0.
- abort asserted during the ACCESS of entry 1 → entry 1 completes, then IDLE; done=0, err=0.
- TIMX_CFG_VERIFY_EN defined, slave returns CCR1 readback 0x3 → err=1, err_idx=1. EGR entry issues no read (nochk).

Source files
------------

// File: rtl/timx_cfg_pkg.sv
// Shared types for the timer configuration sequencer: FSM state encoding,
// timer register offsets and the script entry layout.
package timx_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    ACCESS  = 3'd2,
    VSETUP  = 3'd3,
    VACCESS = 3'd4,
    NEXT    = 3'd5
  } state_t;

  localparam logic [15:0] REG_CR1   = 16'h0000;
  localparam logic [15:0] REG_EGR   = 16'h0014;
  localparam logic [15:0] REG_CCMR1 = 16'h0018;
  localparam logic [15:0] REG_CCER  = 16'h0020;
  localparam logic [15:0] REG_ARR   = 16'h002C;
  localparam logic [15:0] REG_CCR1  = 16'h0034;
  localparam logic [15:0] REG_BDTR  = 16'h0044;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
    logic        nochk;
    logic        last;
  } entry_t;

  function automatic entry_t mk_entry(logic [15:0] addr, logic [31:0] data,
                                      logic nochk, logic last);
    entry_t e;
    e.addr  = addr;
    e.data  = data;
    e.nochk = nochk;
    e.last  = last;
    return e;
  endfunction

endpackage

// File: rtl/timx_cfg_seq_if.sv
// APB link between the configuration sequencer (master) and the timer (slave).
interface timx_cfg_seq_if;
  logic        timx_psel;
  logic        timx_penable;
  logic        timx_pwrite;
  logic [15:0] timx_paddr;
  logic [31:0] timx_pwdata;
  logic [31:0] timx_prdata;
  logic        timx_pready;
  logic        timx_pslverr;

  modport master (
    output timx_psel, timx_penable, timx_pwrite, timx_paddr, timx_pwdata,
    input  timx_prdata, timx_pready, timx_pslverr
  );

  modport slave (
    input  timx_psel, timx_penable, timx_pwrite, timx_paddr, timx_pwdata,
    output timx_prdata, timx_pready, timx_pslverr
  );
endinterface

// File: rtl/timx_cfg_rom.sv
// Default timer bring-up script: ARR, CCR1, CCMR1, CCER, BDTR, EGR.UG, CR1.CEN.
module timx_cfg_rom
  import timx_cfg_pkg::*;
#(
  parameter int unsigned IDX_W = 4
) (
  input  logic [IDX_W-1:0] idx,
  output logic [15:0]      tbl_addr,
  output logic [31:0]      tbl_data,
  output logic             tbl_last,
  output logic             tbl_nochk
);

  entry_t e;

  // Unpopulated slots read as a terminating CR1=0 write.
  always_comb begin
    e = mk_entry(REG_CR1, '0, 1'b1, 1'b1);
    case (int'(idx))
      0: e = mk_entry(REG_ARR,   32'h0000_0008, 1'b0, 1'b0);
      1: e = mk_entry(REG_CCR1,  32'h0000_0002, 1'b0, 1'b0);
      2: e = mk_entry(REG_CCMR1, 32'h0000_0038, 1'b0, 1'b0);
      3: e = mk_entry(REG_CCER,  32'h0000_0005, 1'b0, 1'b0);
      4: e = mk_entry(REG_BDTR,  32'h0000_8000, 1'b0, 1'b0);
      5: e = mk_entry(REG_EGR,   32'h0000_0001, 1'b1, 1'b0);
      6: e = mk_entry(REG_CR1,   32'h0000_0001, 1'b0, 1'b1);
      default: ;
    endcase
  end

  assign tbl_addr  = e.addr;
  assign tbl_data  = e.data;
  assign tbl_last  = e.last;
  assign tbl_nochk = e.nochk;

endmodule

// File: rtl/timx_cfg_seq.sv
// APB write-script replayer for the advanced timer.
// Optional read-back verify is built when TIMX_CFG_VERIFY_EN is defined.
module timx_cfg_seq
  import timx_cfg_pkg::*;
#(
  parameter int unsigned     IDX_W  = 4,
  parameter int unsigned     TO_W   = 8,
  parameter logic [TO_W-1:0] TO_MAX = 8'd200
) (
  input  logic               apb_clk,
  input  logic               apb_rst,
  input  logic               start,
  input  logic               abort,
  output logic [IDX_W-1:0]   tbl_idx,
  input  logic [15:0]        tbl_addr,
  input  logic [31:0]        tbl_data,
  input  logic               tbl_last,
  input  logic               tbl_nochk,
  timx_cfg_seq_if.master     apb,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [IDX_W-1:0]   err_idx
);

  state_t            state, next_state;
  logic [15:0]       paddr_q;
  logic [31:0]       pwdata_q;
  logic              last_q;
  logic [TO_W-1:0]   to_cnt;
  logic              to_hit;
  logic              fail;
  logic              finish;

`ifdef TIMX_CFG_VERIFY_EN
  logic              nochk_q;
`else
  logic              unused_nochk;
  logic              unused_prdata;
  assign unused_nochk  = tbl_nochk;
  assign unused_prdata = ^apb.timx_prdata;
`endif

  assign to_hit = !apb.timx_pready && (to_cnt == TO_MAX - 1'b1);

  always_ff @(posedge apb_clk or posedge apb_rst) begin
    if (apb_rst) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    fail       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE:   if (start) next_state = SETUP;
      SETUP:  next_state = ACCESS;
      ACCESS: begin
        if (apb.timx_pready) begin
          if (apb.timx_pslverr) begin
            fail       = 1'b1;
            next_state = IDLE;
          end else begin
`ifdef TIMX_CFG_VERIFY_EN
            next_state = nochk_q ? NEXT : VSETUP;
`else
            next_state = NEXT;
`endif
          end
        end else if (to_hit) begin
          fail       = 1'b1;
          next_state = IDLE;
        end
      end
`ifdef TIMX_CFG_VERIFY_EN
      VSETUP: next_state = VACCESS;
      VACCESS: begin
        if (apb.timx_pready) begin
          if (apb.timx_pslverr || (apb.timx_prdata != pwdata_q)) begin
            fail       = 1'b1;
            next_state = IDLE;
          end else begin
            next_state = NEXT;
          end
        end else if (to_hit) begin
          fail       = 1'b1;
          next_state = IDLE;
        end
      end
`endif
      NEXT: begin
        // The top index ends the script like tbl_last rather than wrapping.
        if (last_q || abort || (tbl_idx == '1)) begin
          next_state = IDLE;
          finish     = !abort;
        end else begin
          next_state = SETUP;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    apb.timx_psel    = (state == SETUP) || (state == ACCESS) ||
                       (state == VSETUP) || (state == VACCESS);
    apb.timx_penable = (state == ACCESS) || (state == VACCESS);
    apb.timx_pwrite  = (state == SETUP) || (state == ACCESS);
    // Table is presented straight through in SETUP so the address is valid
    // for the whole setup phase; it is held from the register afterwards.
    apb.timx_paddr   = (state == SETUP) ? tbl_addr : paddr_q;
    apb.timx_pwdata  = (state == SETUP) ? tbl_data : pwdata_q;
  end

  always_ff @(posedge apb_clk or posedge apb_rst) begin
    if (apb_rst) begin
      tbl_idx  <= '0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      last_q   <= 1'b0;
      to_cnt   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_idx  <= '0;
`ifdef TIMX_CFG_VERIFY_EN
      nochk_q  <= 1'b0;
`endif
    end else begin
      done <= finish;
      case (state)
        IDLE: if (start) begin
          tbl_idx <= '0;
          err     <= 1'b0;
          busy    <= 1'b1;
        end
        SETUP: begin
          paddr_q  <= tbl_addr;
          pwdata_q <= tbl_data;
          last_q   <= tbl_last;
          to_cnt   <= '0;
`ifdef TIMX_CFG_VERIFY_EN
          nochk_q  <= tbl_nochk;
`endif
        end
        ACCESS, VACCESS: if (!apb.timx_pready) to_cnt <= to_cnt + 1'b1;
        VSETUP: to_cnt <= '0;
        NEXT: if (next_state == SETUP) tbl_idx <= tbl_idx + 1'b1;
        default: ;
      endcase
      if (fail) begin
        err     <= 1'b1;
        err_idx <= tbl_idx;
      end
      if ((state != IDLE) && (next_state == IDLE)) busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_timx_cfg_seq.sv
// Directed bench for timx_cfg_seq: default script, wait states, timeout,
// slave error, abort, index wrap, start-while-busy and async reset.
module tb_timx_cfg_seq;
  import timx_cfg_pkg::*;

`ifdef TIMX_CFG_VERIFY_EN
  localparam int VX = 2;
`else
  localparam int VX = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  tbl_idx;
  logic [15:0] tbl_addr, rom_addr;
  logic [31:0] tbl_data, rom_data;
  logic        tbl_last, tbl_nochk, rom_last, rom_nochk;
  logic        busy, done, err;
  logic [3:0]  err_idx;

  timx_cfg_seq_if bus ();

  timx_cfg_seq #(.IDX_W(4), .TO_W(8), .TO_MAX(8'd200)) dut (
    .apb_clk(clk), .apb_rst(rst), .start(start), .abort(abort),
    .tbl_idx(tbl_idx), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .tbl_last(tbl_last), .tbl_nochk(tbl_nochk), .apb(bus),
    .busy(busy), .done(done), .err(err), .err_idx(err_idx)
  );

  timx_cfg_rom #(.IDX_W(4)) u_rom (
    .idx(tbl_idx), .tbl_addr(rom_addr), .tbl_data(rom_data),
    .tbl_last(rom_last), .tbl_nochk(rom_nochk)
  );

  always #5 clk = ~clk;

  // Test knobs; -1 disables.
  logic use_rom = 1'b1;
  logic bad_ccr1 = 1'b0;
  int   stall_entry = -1, stall_cycles = 0, stuck_entry = -1, slverr_entry = -1;
  int   abort_entry = -1, restart_at = -1;

  always_comb begin
    if (use_rom) begin
      tbl_addr  = rom_addr;
      tbl_data  = rom_data;
      tbl_last  = rom_last;
      tbl_nochk = rom_nochk;
    end else begin
      tbl_addr  = 16'h0100 + {10'd0, tbl_idx, 2'b00};
      tbl_data  = {28'd0, tbl_idx};
      tbl_last  = 1'b0;
      tbl_nochk = 1'b0;
    end
  end

  // Slave model.
  int          acc_cnt = 0;
  logic [31:0] wlast = '0;
  always @(posedge clk) begin
    if (bus.timx_psel && bus.timx_penable && !bus.timx_pready) acc_cnt <= acc_cnt + 1;
    else if (!bus.timx_penable) acc_cnt <= 0;
    if (bus.timx_psel && bus.timx_penable && bus.timx_pready && bus.timx_pwrite)
      wlast <= bus.timx_pwdata;
  end

  always_comb begin
    bus.timx_pready = 1'b1;
    if (bus.timx_pwrite && int'(tbl_idx) == stall_entry && acc_cnt < stall_cycles)
      bus.timx_pready = 1'b0;
    if (bus.timx_pwrite && int'(tbl_idx) == stuck_entry)
      bus.timx_pready = 1'b0;
    bus.timx_pslverr = bus.timx_penable && bus.timx_pwrite && int'(tbl_idx) == slverr_entry;
    bus.timx_prdata  = (bad_ccr1 && bus.timx_paddr == REG_CCR1) ? 32'h3 : wlast;
  end

  // Bus monitor.
  logic [15:0] wa[$];
  logic [31:0] wd[$];
  int n_done = 0, n_reads = 0, n_egr_reads = 0, n_acc3 = 0;
  always @(negedge clk) begin
    if (done) n_done++;
    if (bus.timx_psel && bus.timx_penable && bus.timx_pready) begin
      if (bus.timx_pwrite) begin
        wa.push_back(bus.timx_paddr);
        wd.push_back(bus.timx_pwdata);
      end else begin
        n_reads++;
        if (bus.timx_paddr == REG_EGR) n_egr_reads++;
      end
    end
    if (bus.timx_psel && bus.timx_penable && tbl_idx == 4'd3) n_acc3++;
  end

  int n_vec = 0, n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    wa.delete();
    wd.delete();
    n_done = 0; n_reads = 0; n_egr_reads = 0; n_acc3 = 0;
  endtask

  // Pulse start, count busy cycles until the script ends (bounded).
  task automatic run(input int limit, output int cyc);
    clear_mon();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < limit) begin
      cyc++;
      if (bus.timx_penable && int'(tbl_idx) == abort_entry) abort = 1'b1;
      start = (cyc == restart_at);
      @(negedge clk);
      start = 1'b0;
    end
    if (cyc >= limit) check("busy_timeout", 32'(cyc), 32'(limit - 1));
    repeat (2) @(negedge clk);
    abort = 1'b0;
  endtask

  localparam logic [15:0] EXP_A [7] = '{16'h002C, 16'h0034, 16'h0018, 16'h0020,
                                        16'h0044, 16'h0014, 16'h0000};
  localparam logic [31:0] EXP_D [7] = '{32'h8, 32'h2, 32'h38, 32'h5,
                                        32'h8000, 32'h1, 32'h1};

  task automatic check_script(input string tag);
    check({tag, "_nwr"}, 32'(wa.size()), 32'd7);
    for (int i = 0; i < 7 && i < wa.size(); i++) begin
      check($sformatf("%s_a%0d", tag, i), {16'd0, wa[i]}, {16'd0, EXP_A[i]});
      check($sformatf("%s_d%0d", tag, i), wd[i], EXP_D[i]);
    end
    check({tag, "_done"}, 32'(n_done), 32'd1);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  int cyc;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_psel", {31'd0, bus.timx_psel}, 32'd0);
    check("rst_penable", {31'd0, bus.timx_penable}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_err_idx", {28'd0, err_idx}, 32'd0);
    check("rst_tbl_idx", {28'd0, tbl_idx}, 32'd0);
    rst = 1'b0;

    // Default script, pready=1.
    run(400, cyc);
    check("def_cycles", 32'(cyc), 32'(21 + 6 * VX));
    check_script("def");
    check("def_reads", 32'(n_reads), 32'(6 * VX / 2));
    check("def_egr_reads", 32'(n_egr_reads), 32'd0);

    // Three wait states on entry 2.
    stall_entry = 2; stall_cycles = 3;
    run(400, cyc);
    stall_entry = -1;
    check("stall_cycles", 32'(cyc), 32'(24 + 6 * VX));
    check_script("stall");

    // pready stuck low on entry 3: timeout.
    stuck_entry = 3;
    run(600, cyc);
    stuck_entry = -1;
    check("to_cycles", 32'(cyc), 32'(210 + 3 * VX));
    check("to_acc", 32'(n_acc3), 32'd200);
    check("to_err", {31'd0, err}, 32'd1);
    check("to_err_idx", {28'd0, err_idx}, 32'd3);
    check("to_psel", {31'd0, bus.timx_psel}, 32'd0);
    check("to_done", 32'(n_done), 32'd0);
    check("to_nwr", 32'(wa.size()), 32'd3);

    // Slave error on entry 4, then a clean rerun.
    slverr_entry = 4;
    run(400, cyc);
    slverr_entry = -1;
    check("se_cycles", 32'(cyc), 32'(14 + 4 * VX));
    check("se_err", {31'd0, err}, 32'd1);
    check("se_err_idx", {28'd0, err_idx}, 32'd4);
    check("se_done", 32'(n_done), 32'd0);
    check("se_nwr", 32'(wa.size()), 32'd5);
    repeat (5) @(negedge clk);
    check("se_sticky", {31'd0, err}, 32'd1);
    check("se_idle_psel", {31'd0, bus.timx_psel}, 32'd0);
    run(400, cyc);
    check("rerun_cycles", 32'(cyc), 32'(21 + 6 * VX));
    check_script("rerun");

    // Abort during the write of entry 1.
    abort_entry = 1;
    run(400, cyc);
    abort_entry = -1;
    check("ab_cycles", 32'(cyc), 32'(6 + 2 * VX));
    check("ab_nwr", 32'(wa.size()), 32'd2);
    check("ab_a1", {16'd0, wa[1]}, 32'h34);
    check("ab_done", 32'(n_done), 32'd0);
    check("ab_err", {31'd0, err}, 32'd0);

    // Start pulses while busy are ignored.
    restart_at = 5;
    run(400, cyc);
    restart_at = -1;
    check("rs_cycles", 32'(cyc), 32'(21 + 6 * VX));
    check_script("rs");

    // No tbl_last anywhere: script stops at the top index.
    use_rom = 1'b0;
    run(800, cyc);
    check("wrap_cycles", 32'(cyc), 32'(48 + 16 * VX));
    check("wrap_nwr", 32'(wa.size()), 32'd16);
    if (wa.size() == 16) check("wrap_last_a", {16'd0, wa[15]}, 32'h013C);
    check("wrap_idx", {28'd0, tbl_idx}, 32'd15);
    check("wrap_done", 32'(n_done), 32'd1);
    use_rom = 1'b1;

`ifdef TIMX_CFG_VERIFY_EN
    bad_ccr1 = 1'b1;
    run(400, cyc);
    bad_ccr1 = 1'b0;
    check("vf_cycles", 32'(cyc), 32'd9);
    check("vf_err", {31'd0, err}, 32'd1);
    check("vf_err_idx", {28'd0, err_idx}, 32'd1);
    check("vf_done", 32'(n_done), 32'd0);
`endif

    // Asynchronous reset in the middle of a transfer.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10 && !bus.timx_penable; i++) @(negedge clk);
    check("ar_in_access", {31'd0, bus.timx_penable}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_psel", {31'd0, bus.timx_psel}, 32'd0);
    check("ar_penable", {31'd0, bus.timx_penable}, 32'd0);
    check("ar_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("ar_stays_idle", {31'd0, busy}, 32'd0);
    check("ar_idx", {28'd0, tbl_idx}, 32'd0);
    run(400, cyc);
    check_script("ar_rerun");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
